// File: rtl/config_mem_loader_pkg.sv
// rtl/config_mem_loader_pkg.sv - shared types, default sizes and burst bound check for the config loader
package config_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_NUM_WORDS = 38;

    // A burst is legal when it carries at least one word and its last word
    // lands inside the image. Evaluated on wide unsigned values so that
    // addr + len can never wrap and sneak past the check.
    function automatic logic burst_in_range(
        input int unsigned addr,
        input int unsigned len,
        input int unsigned num_words
    );
        return (len != 0) && ((addr + len) <= num_words);
    endfunction

endpackage

// File: rtl/config_word_bank.sv
// rtl/config_word_bank.sv - configuration word storage with per-word written mask
module config_word_bank
    import config_mem_loader_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter int ADDR_W    = $clog2(DEFAULT_NUM_WORDS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]           wr_data,
    output logic [DATA_W*NUM_WORDS-1:0] image,
    output logic                        all_written
);

    logic [DATA_W-1:0]    words [NUM_WORDS];
    logic [NUM_WORDS-1:0] mask;
    logic [NUM_WORDS-1:0] mask_next;

    // Mask as it will look after this cycle's write, so the all-written flag
    // rises together with the final word becoming visible.
    always_comb begin
        mask_next = mask;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (wr_en && (wr_idx == ADDR_W'(i))) begin
                mask_next[i] = 1'b1;
            end
        end
    end

    // Word storage, mask and sticky all-written flag; reset wipes the whole image.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                words[i] <= '0;
            end
            mask        <= '0;
            all_written <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (wr_en && (wr_idx == ADDR_W'(i))) begin
                    words[i] <= wr_data;
                end
            end
            mask        <= mask_next;
            all_written <= &mask_next;
        end
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_flatten
        assign image[g*DATA_W +: DATA_W] = words[g];
    end

endmodule

// File: rtl/config_mem_loader.sv
// rtl/config_mem_loader.sv - burst-loaded configuration image (optional CONFIG_MEM_LOADER_PARITY_EN)
module config_mem_loader
    import config_mem_loader_pkg::*;
#(
    parameter  int DATA_W    = DEFAULT_DATA_W,
    parameter  int NUM_WORDS = DEFAULT_NUM_WORDS,
    localparam int ADDR_W    = $clog2(NUM_WORDS),
    localparam int LEN_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        io_cmd_valid,
    output logic                        io_cmd_ready,
    input  logic [ADDR_W-1:0]           io_cmd_addr,
    input  logic [LEN_W-1:0]            io_cmd_len,
    input  logic                        io_d_valid,
    output logic                        io_d_ready,
    input  logic [DATA_W-1:0]           io_d_in,
`ifdef CONFIG_MEM_LOADER_PARITY_EN
    input  logic                        io_d_par,
`endif
    output logic                        io_busy,
    output logic                        io_done,
    output logic                        io_err,
    output logic [DATA_W*NUM_WORDS-1:0] io_configs_out,
    output logic                        io_configs_valid
);

    loader_state_t     state;
    loader_state_t     state_next;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  remaining;
    logic              cmd_ok;
    logic              cmd_accept;
    logic              cmd_reject;
    logic              d_hs;
    logic              word_wr;
    logic              err_q;
    logic              par_fail_q;

    assign cmd_ok     = burst_in_range(32'(io_cmd_addr), 32'(io_cmd_len), 32'(NUM_WORDS));
    assign cmd_accept = (state == IDLE) && io_cmd_valid && cmd_ok;
    assign cmd_reject = (state == IDLE) && io_cmd_valid && !cmd_ok;
    assign d_hs       = io_d_valid && io_d_ready;

`ifdef CONFIG_MEM_LOADER_PARITY_EN
    logic par_ok;
    assign par_ok  = ((^io_d_in) == io_d_par);
    assign word_wr = d_hs && par_ok;
`else
    assign word_wr = d_hs;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a burst ends on the handshake that carries its last word.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (d_hs && (remaining == LEN_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode; io_err merges the rejected-command pulse with a parity failure report at DONE.
    always_comb begin
        io_cmd_ready = 1'b0;
        io_d_ready   = 1'b0;
        io_busy      = 1'b0;
        io_done      = 1'b0;
        io_err       = err_q;
        case (state)
            IDLE: io_cmd_ready = 1'b1;
            LOAD: begin
                io_d_ready = 1'b1;
                io_busy    = 1'b1;
            end
            DONE: begin
                io_done = 1'b1;
                io_err  = err_q | par_fail_q;
            end
            default: begin
                io_cmd_ready = 1'b0;
            end
        endcase
    end

    // Burst pointer/counter, reject pulse and sticky parity-failure flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            remaining  <= '0;
            err_q      <= 1'b0;
            par_fail_q <= 1'b0;
        end else begin
            err_q <= cmd_reject;
            if (cmd_accept) begin
                ptr        <= io_cmd_addr;
                remaining  <= io_cmd_len;
                par_fail_q <= 1'b0;
            end else if (d_hs) begin
                ptr       <= ptr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
                if (!word_wr) begin
                    par_fail_q <= 1'b1;
                end
            end
        end
    end

    config_word_bank #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (word_wr),
        .wr_idx      (ptr),
        .wr_data     (io_d_in),
        .image       (io_configs_out),
        .all_written (io_configs_valid)
    );

endmodule

// File: tb/tb_config_mem_loader.sv
// tb/tb_config_mem_loader.sv - randomized self-checking bench for config_mem_loader
module tb_config_mem_loader;

    localparam int DW = 32;
    localparam int NW = 38;
    localparam int AW = $clog2(NW);
    localparam int LW = $clog2(NW + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              io_cmd_valid = 1'b0;
    logic              io_cmd_ready;
    logic [AW-1:0]     io_cmd_addr = '0;
    logic [LW-1:0]     io_cmd_len = '0;
    logic              io_d_valid = 1'b0;
    logic              io_d_ready;
    logic [DW-1:0]     io_d_in = '0;
`ifdef CONFIG_MEM_LOADER_PARITY_EN
    logic              io_d_par = 1'b0;
`endif
    logic              io_busy;
    logic              io_done;
    logic              io_err;
    logic [DW*NW-1:0]  io_configs_out;
    logic              io_configs_valid;

    config_mem_loader dut (
        .clk              (clk),
        .reset            (reset),
        .io_cmd_valid     (io_cmd_valid),
        .io_cmd_ready     (io_cmd_ready),
        .io_cmd_addr      (io_cmd_addr),
        .io_cmd_len       (io_cmd_len),
        .io_d_valid       (io_d_valid),
        .io_d_ready       (io_d_ready),
        .io_d_in          (io_d_in),
`ifdef CONFIG_MEM_LOADER_PARITY_EN
        .io_d_par         (io_d_par),
`endif
        .io_busy          (io_busy),
        .io_done          (io_done),
        .io_err           (io_err),
        .io_configs_out   (io_configs_out),
        .io_configs_valid (io_configs_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference image: what each word should hold, which words were written, and the sticky flag.
    logic [DW-1:0] exp_words [NW];
    logic [NW-1:0] exp_mask;
    bit            exp_valid;
    int            cur_ptr;
    int            cur_len;
    bit            last_ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] img_word(input int i);
        return io_configs_out[i*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NW; i++) exp_words[i] = '0;
        exp_mask  = '0;
        exp_valid = 1'b0;
    endtask

    task automatic check_image();
        for (int i = 0; i < NW; i++) check($sformatf("img[%0d]", i), img_word(i), exp_words[i]);
        check("configs_valid", 32'(io_configs_valid), 32'(exp_valid));
    endtask

    task automatic send_cmd(input int addr, input int len);
        bit ok;
        ok = (len != 0) && (addr + len <= NW);
        check("cmd_ready_idle", 32'(io_cmd_ready), 1);
        io_cmd_valid = 1'b1;
        io_cmd_addr  = AW'(addr);
        io_cmd_len   = LW'(len);
        tick();
        io_cmd_valid = 1'b0;
        check($sformatf("cmd_err a=%0d l=%0d", addr, len), 32'(io_err), 32'(!ok));
        check($sformatf("cmd_busy a=%0d l=%0d", addr, len), 32'(io_busy), 32'(ok));
        if (ok) begin
            cur_ptr = addr;
            cur_len = len;
        end else begin
            tick();
            check("err_one_cycle", 32'(io_err), 0);
            check("reject_stays_idle", 32'(io_cmd_ready), 1);
        end
        last_ok = ok;
    endtask

    // mode 0: back-to-back, 1: valid toggles, 2: random gaps. base>=0 gives data base+n.
    task automatic send_data(input int mode, input int base, input int stop_after, input int bad_idx);
        int n;
        int cyc;
        bit fail_any;
        bit v;
        bit bad;
        logic [DW-1:0] d;
        n = 0;
        cyc = 0;
        fail_any = 1'b0;
        while (n < cur_len && n != stop_after && cyc < 400) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 2) != 0);
            d = (base >= 0) ? DW'(base + n) : DW'($urandom);
            bad = 1'b0;
`ifdef CONFIG_MEM_LOADER_PARITY_EN
            bad = (n == bad_idx);
            io_d_par = (^d) ^ bad;
`endif
            check("load_d_ready", 32'(io_d_ready), 1);
            check("load_cmd_ready", 32'(io_cmd_ready), 0);
            io_d_valid = v;
            io_d_in    = d;
            tick();
            if (v) begin
                if (bad) begin
                    fail_any = 1'b1;
                end else begin
                    exp_words[cur_ptr] = d;
                    exp_mask[cur_ptr]  = 1'b1;
                    if (&exp_mask) exp_valid = 1'b1;
                end
                check($sformatf("wr_word[%0d]", cur_ptr), img_word(cur_ptr), exp_words[cur_ptr]);
                cur_ptr++;
                n++;
            end
            cyc++;
        end
        io_d_valid = 1'b0;
        if (cyc >= 400) check("data_cycle_budget", 32'(n), 32'(cur_len));
        if (n == cur_len) begin
            check("done_pulse", 32'(io_done), 1);
            check("done_busy", 32'(io_busy), 0);
            check("done_d_ready", 32'(io_d_ready), 0);
            check("done_cmd_ready", 32'(io_cmd_ready), 0);
            check("done_err", 32'(io_err), 32'(fail_any));
            tick();
            check("done_one_cycle", 32'(io_done), 0);
            check("idle_cmd_ready", 32'(io_cmd_ready), 1);
            check("idle_busy", 32'(io_busy), 0);
            check("idle_err", 32'(io_err), 0);
            check_image();
        end
    endtask

    initial begin
        int a;
        int l;
        model_clear();
        tick();
        tick();
        check("rst_cmd_ready", 32'(io_cmd_ready), 1);
        check("rst_busy", 32'(io_busy), 0);
        check("rst_done", 32'(io_done), 0);
        check("rst_err", 32'(io_err), 0);
        check("rst_d_ready", 32'(io_d_ready), 0);
        check_image();
        reset = 1'b0;
        tick();

        // Full image, back-to-back.
        send_cmd(0, 38);
        send_data(0, 'h1000, -1, -1);
        check("word37", img_word(37), 32'h1025);
        check("full_valid", 32'(io_configs_valid), 1);

        // Out-of-range and empty bursts are rejected without touching the image.
        send_cmd(36, 3);
        check_image();
        send_cmd(5, 0);
        send_cmd(50, 1);

        // Two words with valid toggling.
        send_cmd(5, 2);
        send_data(1, -1, -1, -1);

        // A command held during LOAD is ignored, then taken on the first IDLE cycle.
        send_cmd(0, 3);
        io_cmd_valid = 1'b1;
        io_cmd_addr  = AW'(10);
        io_cmd_len   = LW'(2);
        send_data(2, -1, -1, -1);
        check("held_ready_idle", 32'(io_cmd_ready), 1);
        tick();
        io_cmd_valid = 1'b0;
        check("held_accepted", 32'(io_busy), 1);
        cur_ptr = 10;
        cur_len = 2;
        send_data(0, -1, -1, -1);

        // Random bursts, some illegal.
        repeat (25) begin
            a = $urandom_range(0, 45);
            l = $urandom_range(0, 12);
            send_cmd(a, l);
            if (last_ok) send_data($urandom_range(0, 2), -1, -1, -1);
        end

`ifdef CONFIG_MEM_LOADER_PARITY_EN
        // Bad parity on the third word: skipped write, error reported with done.
        send_cmd(10, 4);
        send_data(0, -1, -1, 2);
        send_cmd(10, 1);
        send_data(0, -1, -1, -1);
`endif

        // Reset in the middle of a full burst.
        send_cmd(0, 38);
        send_data(0, -1, 10, -1);
        reset = 1'b1;
        tick();
        model_clear();
        check("midrst_busy", 32'(io_busy), 0);
        check("midrst_cmd_ready", 32'(io_cmd_ready), 1);
        check_image();
        reset = 1'b0;
        tick();
        send_cmd(2, 3);
        send_data(0, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
